// File: rtl/apb_window_wdog_pkg.sv
// rtl/apb_window_wdog_pkg.sv - register map, bit indices and address decode for the windowed watchdog
package apb_window_wdog_pkg;

    localparam logic [11:0] OFF_LOAD   = 12'h000;
    localparam logic [11:0] OFF_VALUE  = 12'h004;
    localparam logic [11:0] OFF_CTRL   = 12'h008;
    localparam logic [11:0] OFF_KICK   = 12'h00C;
    localparam logic [11:0] OFF_RIS    = 12'h010;
    localparam logic [11:0] OFF_MIS    = 12'h014;
    localparam logic [11:0] OFF_WINDOW = 12'h018;
    localparam logic [11:0] OFF_PRESC  = 12'h01C;
    localparam logic [11:0] OFF_LOCK   = 12'hC00;

    localparam int CTRL_INTEN  = 0;
    localparam int CTRL_RESEN  = 1;
    localparam int CTRL_WINEN  = 2;
    localparam int RIS_TIMEOUT = 0;
    localparam int RIS_EARLY   = 1;

    localparam logic [31:0] UNLOCK_KEY = 32'h1ACCE551;

    typedef enum logic [3:0] {
        REG_LOAD,
        REG_VALUE,
        REG_CTRL,
        REG_KICK,
        REG_RIS,
        REG_MIS,
        REG_WINDOW,
        REG_PRESC,
        REG_LOCK,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [11:2] paddr);
        reg_sel_e sel;
        case ({paddr, 2'b00})
            OFF_LOAD:   sel = REG_LOAD;
            OFF_VALUE:  sel = REG_VALUE;
            OFF_CTRL:   sel = REG_CTRL;
            OFF_KICK:   sel = REG_KICK;
            OFF_RIS:    sel = REG_RIS;
            OFF_MIS:    sel = REG_MIS;
            OFF_WINDOW: sel = REG_WINDOW;
            OFF_PRESC:  sel = REG_PRESC;
            OFF_LOCK:   sel = REG_LOCK;
            default:    sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/apb_window_wdog_if.sv
// rtl/apb_window_wdog_if.sv - APB3 slave bus bundle for the windowed watchdog
interface apb_window_wdog_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [11:2] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_window_wdog_cnt.sv
// rtl/apb_window_wdog_cnt.sv - prescaler, down counter, timeout/early flags and sticky reset request
module apb_window_wdog_cnt
    import apb_window_wdog_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               clken,
    input  logic               inten,
    input  logic               resen,
    input  logic               winen,
    input  logic [CNT_W-1:0]   load_val,
    input  logic [CNT_W-1:0]   window,
    input  logic [PRESC_W-1:0] presc,
    input  logic               load_wr,
    input  logic [CNT_W-1:0]   load_new,
    input  logic               kick_wr,
    output logic [CNT_W-1:0]   value,
    output logic               timeout,
    output logic               timeout_nxt,
    output logic               early,
    output logic               wdogres
);
    logic [PRESC_W-1:0] pcnt_q;
    logic [CNT_W-1:0]   value_q;
    logic               timeout_q;
    logic               early_q;
    logic               res_q;
    logic               tick;
    logic               at_zero;
    logic               in_window;
    logic               kick_ok;
    logic               kick_early;
    logic               zero_tick;

    assign tick       = inten & clken & (pcnt_q == '0);
    assign at_zero    = (value_q == '0);
    assign in_window  = ~winen | (value_q <= window);
    assign kick_ok    = kick_wr & in_window;
    assign kick_early = kick_wr & ~in_window;
    // A LOAD write or a valid kick in the same cycle swallows the tick's timeout effect.
    assign zero_tick  = tick & at_zero & ~load_wr & ~kick_ok;

    always_comb begin
        timeout_nxt = timeout_q;
        if (kick_ok) begin
            timeout_nxt = 1'b0;
        end else if (zero_tick) begin
            timeout_nxt = 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pcnt_q    <= '0;
            value_q   <= '1;
            timeout_q <= 1'b0;
            early_q   <= 1'b0;
            res_q     <= 1'b0;
        end else begin
            timeout_q <= timeout_nxt;
            if (kick_ok) begin
                pcnt_q <= presc;
            end else if (inten & clken) begin
                pcnt_q <= (pcnt_q == '0) ? presc : pcnt_q - 1'b1;
            end
            if (load_wr) begin
                value_q <= load_new;
            end else if (kick_ok) begin
                value_q <= load_val;
            end else if (tick) begin
                value_q <= at_zero ? load_val : value_q - 1'b1;
            end
            if (kick_early) begin
                early_q <= 1'b1;
            end
            if (resen & ((zero_tick & timeout_q) | kick_early)) begin
                res_q <= 1'b1;
            end
        end
    end

    assign value   = value_q;
    assign timeout = timeout_q;
    assign early   = early_q;
    assign wdogres = res_q;
endmodule

// File: rtl/apb_window_wdog.sv
// rtl/apb_window_wdog.sv - APB3 windowed watchdog: decode, register file, lock and error response
module apb_window_wdog
    import apb_window_wdog_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    apb_window_wdog_if.slave apb,
    input  logic             WDOGCLKEN,
    output logic             WDOGINT,
    output logic             WDOGRES
);
    reg_sel_e           sel;
    logic               acc;
    logic               err;
    logic               wr_ok;
    logic [CNT_W-1:0]   load_q;
    logic [CNT_W-1:0]   window_q;
    logic [PRESC_W-1:0] presc_q;
    logic [2:0]         ctrl_q;
    logic               lock_q;
    logic               inten_nxt;
    logic               int_q;
    logic [CNT_W-1:0]   value;
    logic               timeout;
    logic               timeout_nxt;
    logic               early;
    logic [1:0]         ris_v;
    logic [1:0]         mis_v;
    logic [31:0]        rdata;

    assign sel = decode_addr(apb.PADDR);
    assign acc = apb.PSEL & apb.PENABLE;

    always_comb begin
        err = 1'b0;
        if (acc) begin
            if (sel == REG_NONE) begin
                err = 1'b1;
            end else if (apb.PWRITE) begin
                err = (lock_q && sel != REG_LOCK) || sel == REG_VALUE || sel == REG_RIS || sel == REG_MIS;
            end else begin
                err = (sel == REG_KICK);
            end
        end
    end

    assign wr_ok = acc & apb.PWRITE & ~err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            load_q   <= '1;
            window_q <= '1;
            presc_q  <= '0;
            ctrl_q   <= '0;
            lock_q   <= 1'b0;
        end else if (wr_ok) begin
            case (sel)
                REG_LOAD:   load_q   <= apb.PWDATA[CNT_W-1:0];
                REG_CTRL:   ctrl_q   <= apb.PWDATA[2:0];
                REG_WINDOW: window_q <= apb.PWDATA[CNT_W-1:0];
                REG_PRESC:  presc_q  <= apb.PWDATA[PRESC_W-1:0];
                REG_LOCK:   lock_q   <= (apb.PWDATA != UNLOCK_KEY);
                default:    ;
            endcase
        end
    end

    apb_window_wdog_cnt #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_cnt (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .clken       (WDOGCLKEN),
        .inten       (ctrl_q[CTRL_INTEN]),
        .resen       (ctrl_q[CTRL_RESEN]),
        .winen       (ctrl_q[CTRL_WINEN]),
        .load_val    (load_q),
        .window      (window_q),
        .presc       (presc_q),
        .load_wr     (wr_ok && sel == REG_LOAD),
        .load_new    (apb.PWDATA[CNT_W-1:0]),
        .kick_wr     (wr_ok && sel == REG_KICK),
        .value       (value),
        .timeout     (timeout),
        .timeout_nxt (timeout_nxt),
        .early       (early),
        .wdogres     (WDOGRES)
    );

    // Interrupt flop tracks next-state TIMEOUT and INTEN so it never lags the RIS bit.
    assign inten_nxt = (wr_ok && sel == REG_CTRL) ? apb.PWDATA[CTRL_INTEN] : ctrl_q[CTRL_INTEN];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            int_q <= 1'b0;
        end else begin
            int_q <= timeout_nxt & inten_nxt;
        end
    end

    assign WDOGINT = int_q;

    always_comb begin
        ris_v              = '0;
        ris_v[RIS_TIMEOUT] = timeout;
        ris_v[RIS_EARLY]   = early;
        mis_v              = '0;
        mis_v[RIS_TIMEOUT] = timeout & ctrl_q[CTRL_INTEN];
        mis_v[RIS_EARLY]   = early & ctrl_q[CTRL_RESEN];
    end

    always_comb begin
        rdata = '0;
        case (sel)
            REG_LOAD:   rdata = 32'(load_q);
            REG_VALUE:  rdata = 32'(value);
            REG_CTRL:   rdata = 32'(ctrl_q);
            REG_RIS:    rdata = 32'(ris_v);
            REG_MIS:    rdata = 32'(mis_v);
            REG_WINDOW: rdata = 32'(window_q);
            REG_PRESC:  rdata = 32'(presc_q);
            REG_LOCK:   rdata = 32'(lock_q);
            default:    rdata = '0;
        endcase
    end

    assign apb.PRDATA  = (PRESETn && acc && !apb.PWRITE && !err) ? rdata : 32'h0;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = PRESETn & err;
endmodule

// File: tb/tb_apb_window_wdog.sv
// tb/tb_apb_window_wdog.sv - randomized and directed checks of apb_window_wdog against a cycle reference model
module tb_apb_window_wdog;
    localparam int          CNT_W   = 16;
    localparam int          PRESC_W = 8;
    localparam logic [31:0] MASK    = 32'h0000_FFFF;
    localparam logic [31:0] PMASK   = 32'h0000_00FF;
    localparam logic [31:0] KEY     = 32'h1ACCE551;
    localparam logic [11:0] A_LOAD = 12'h000, A_VALUE = 12'h004, A_CTRL = 12'h008, A_KICK = 12'h00C;
    localparam logic [11:0] A_RIS = 12'h010, A_MIS = 12'h014, A_WINDOW = 12'h018, A_PRESC = 12'h01C;
    localparam logic [11:0] A_LOCK = 12'hC00;

    typedef struct {
        logic [31:0] load;
        logic [31:0] value;
        logic [31:0] window;
        logic [31:0] presc;
        logic [31:0] pcnt;
        logic [2:0]  ctrl;
        logic        lock;
        logic        to;
        logic        early;
        logic        res;
        logic        intr;
    } mstate_t;

    logic    PCLK = 1'b0;
    logic    PRESETn;
    logic    WDOGCLKEN;
    logic    WDOGINT;
    logic    WDOGRES;
    int      total = 0;
    int      bad = 0;
    int      cyc = 0;
    int      clk_mode = 0;
    mstate_t m;
    mstate_t n;

    apb_window_wdog_if bus ();

    apb_window_wdog #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .apb       (bus),
        .WDOGCLKEN (WDOGCLKEN),
        .WDOGINT   (WDOGINT),
        .WDOGRES   (WDOGRES)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_err(input logic [11:0] a, input logic wr);
        if (!(a inside {A_LOAD, A_VALUE, A_CTRL, A_KICK, A_RIS, A_MIS, A_WINDOW, A_PRESC, A_LOCK})) return 1'b1;
        if (wr) return (m.lock && a != A_LOCK) || a == A_VALUE || a == A_RIS || a == A_MIS;
        return a == A_KICK;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [11:0] a);
        case (a)
            A_LOAD:   return m.load;
            A_VALUE:  return m.value;
            A_CTRL:   return {29'b0, m.ctrl};
            A_RIS:    return {30'b0, m.early, m.to};
            A_MIS:    return {30'b0, m.early & m.ctrl[1], m.to & m.ctrl[0]};
            A_WINDOW: return m.window;
            A_PRESC:  return m.presc;
            A_LOCK:   return {31'b0, m.lock};
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m.load = MASK; m.value = MASK; m.window = MASK; m.presc = 0; m.pcnt = 0;
        m.ctrl = 0; m.lock = 0; m.to = 0; m.early = 0; m.res = 0; m.intr = 0;
    endtask

    // Next state from the rules: register writes, then kick/load/tick priority on the counter.
    task automatic model_eval();
        logic [11:0] a;
        logic        wr_ok, tick, win_ok;
        a     = {bus.PADDR, 2'b00};
        wr_ok = bus.PSEL && bus.PENABLE && bus.PWRITE && !exp_err(a, 1'b1);
        n     = m;
        tick  = m.ctrl[0] && WDOGCLKEN && m.pcnt == 0;
        if (m.ctrl[0] && WDOGCLKEN) n.pcnt = (m.pcnt == 0) ? m.presc : m.pcnt - 1;
        if (wr_ok) begin
            case (a)
                A_LOAD:   n.load = bus.PWDATA & MASK;
                A_CTRL:   n.ctrl = bus.PWDATA[2:0];
                A_WINDOW: n.window = bus.PWDATA & MASK;
                A_PRESC:  n.presc = bus.PWDATA & PMASK;
                A_LOCK:   n.lock = (bus.PWDATA != KEY);
                default:  ;
            endcase
        end
        win_ok = !m.ctrl[2] || m.value <= m.window;
        if (wr_ok && a == A_LOAD) begin
            n.value = bus.PWDATA & MASK;
        end else if (wr_ok && a == A_KICK && win_ok) begin
            n.value = m.load; n.to = 0; n.pcnt = m.presc;
        end else begin
            if (wr_ok && a == A_KICK) begin
                n.early = 1;
                if (m.ctrl[1]) n.res = 1;
            end
            if (tick && m.value == 0) begin
                n.value = m.load;
                if (m.to && m.ctrl[1]) n.res = 1;
                n.to = 1;
            end else if (tick) begin
                n.value = m.value - 1;
            end
        end
        n.intr = n.to && n.ctrl[0];
    endtask

    task automatic step();
        case (clk_mode)
            0:       WDOGCLKEN = 1'b0;
            1:       WDOGCLKEN = 1'b1;
            2:       WDOGCLKEN = cyc[0];
            3:       WDOGCLKEN = 1'($urandom_range(0, 1));
            default: WDOGCLKEN = bus.PENABLE;
        endcase
        model_eval();
        @(posedge PCLK);
        m = n;
        cyc++;
        @(negedge PCLK);
        check_eq("int", WDOGINT, m.intr);
        check_eq("res", WDOGRES, m.res);
    endtask

    task automatic bus_idle();
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
    endtask

    task automatic apb_wr(input logic [11:0] addr, input logic [31:0] data, input string tag);
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = addr[11:2]; bus.PWDATA = data;
        step();
        bus.PENABLE = 1;
        #1;
        check_eq({tag, ".err"}, bus.PSLVERR, exp_err(addr, 1'b1));
        step();
        bus_idle();
    endtask

    task automatic apb_rd(input logic [11:0] addr, input string tag, output logic [31:0] data);
        logic e;
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = addr[11:2];
        step();
        bus.PENABLE = 1;
        #1;
        e = exp_err(addr, 1'b0);
        check_eq({tag, ".err"}, bus.PSLVERR, e);
        check_eq({tag, ".rd"}, bus.PRDATA, e ? 32'h0 : exp_rdata(addr));
        data = bus.PRDATA;
        step();
        bus_idle();
    endtask

    // Reset lands between clock edges; outputs must drop without waiting for an edge.
    task automatic do_reset(input string tag);
        #2 PRESETn = 1'b0;
        #1;
        check_eq({tag, ".int"}, WDOGINT, 0);
        check_eq({tag, ".res"}, WDOGRES, 0);
        check_eq({tag, ".prdata"}, bus.PRDATA, 0);
        check_eq({tag, ".pslverr"}, bus.PSLVERR, 0);
        model_reset();
        @(negedge PCLK);
        bus_idle();
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    initial begin
        logic [31:0] d, prev;
        logic [11:0] addr_tab [12];
        logic [11:0] a;
        int t1, t2;
        addr_tab = '{A_LOAD, A_VALUE, A_CTRL, A_KICK, A_RIS, A_MIS, A_WINDOW, A_PRESC, A_LOCK,
                     12'h020, 12'h3FC, 12'hC04};
        PRESETn = 1'b0; WDOGCLKEN = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
        bus_idle();
        model_reset();
        @(negedge PCLK);
        check_eq("rst.int", WDOGINT, 0);
        check_eq("rst.res", WDOGRES, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        check_eq("rst.prdata_idle", bus.PRDATA, 0);

        apb_rd(A_LOAD, "rst.load", d);     check_eq("rst.load_c", d, 32'hFFFF);
        apb_rd(A_VALUE, "rst.value", d);   check_eq("rst.value_c", d, 32'hFFFF);
        apb_rd(A_WINDOW, "rst.window", d); check_eq("rst.window_c", d, 32'hFFFF);
        apb_rd(A_CTRL, "rst.ctrl", d);     check_eq("rst.ctrl_c", d, 0);
        apb_rd(A_PRESC, "rst.presc", d);   check_eq("rst.presc_c", d, 0);
        apb_rd(A_RIS, "rst.ris", d);       check_eq("rst.ris_c", d, 0);
        apb_rd(A_LOCK, "rst.lock", d);     check_eq("rst.lock_c", d, 0);
        apb_rd(A_KICK, "rst.kick_rd", d);

        // Timeout then reset request with LOAD=3, PRESC=0.
        clk_mode = 0;
        apb_wr(A_LOAD, 3, "to.load");
        clk_mode = 1;
        apb_wr(A_CTRL, 3, "to.ctrl");
        repeat (3) step();
        check_eq("to.int_before", WDOGINT, 0);
        step();
        check_eq("to.int_at4", WDOGINT, 1);
        check_eq("to.res_at4", WDOGRES, 0);
        repeat (3) step();
        check_eq("to.res_before8", WDOGRES, 0);
        step();
        check_eq("to.res_at8", WDOGRES, 1);

        // Reset in the middle of a read access while the reset request is high.
        bus.PSEL = 1; bus.PWRITE = 0; bus.PADDR = A_VALUE[11:2]; bus.PENABLE = 1;
        do_reset("mid");
        clk_mode = 0;
        apb_rd(A_VALUE, "mid.value", d); check_eq("mid.value_c", d, 32'hFFFF);

        // Window: valid kick at VALUE=4, early kick at VALUE=12.
        apb_wr(A_WINDOW, 5, "win.window");
        apb_wr(A_LOAD, 20, "win.load");
        apb_wr(A_CTRL, 7, "win.ctrl");
        clk_mode = 1; repeat (16) step(); clk_mode = 0;
        apb_rd(A_VALUE, "win.v4", d); check_eq("win.v4_c", d, 4);
        apb_wr(A_KICK, 32'h0, "win.kick_ok");
        check_eq("win.res_ok", WDOGRES, 0);
        apb_rd(A_VALUE, "win.reload", d); check_eq("win.reload_c", d, 20);
        apb_rd(A_RIS, "win.ris_ok", d);   check_eq("win.ris_ok_c", d, 0);
        clk_mode = 1; repeat (8) step(); clk_mode = 0;
        apb_wr(A_KICK, 32'h0, "win.kick_early");
        check_eq("win.res_early", WDOGRES, 1);
        apb_rd(A_RIS, "win.ris_early", d);   check_eq("win.ris_early_c", d, 2);
        apb_rd(A_VALUE, "win.v_early", d);   check_eq("win.v_early_c", d, 12);
        do_reset("win");

        // Lock.
        apb_wr(A_LOCK, 0, "lock.set");
        apb_wr(A_LOAD, 32'h55, "lock.blocked");
        apb_rd(A_LOAD, "lock.load", d); check_eq("lock.load_c", d, 32'hFFFF);
        apb_wr(A_LOCK, KEY, "lock.clear");
        apb_wr(A_LOAD, 32'h55, "lock.open");
        apb_rd(A_LOAD, "lock.load2", d); check_eq("lock.load2_c", d, 32'h55);

        // LOAD write and valid KICK each coinciding with a zero tick.
        apb_wr(A_LOAD, 0, "coll.load0");
        apb_wr(A_CTRL, 1, "coll.ctrl");
        clk_mode = 4; apb_wr(A_LOAD, 9, "coll.load9"); clk_mode = 0;
        apb_rd(A_VALUE, "coll.value", d); check_eq("coll.value_c", d, 9);
        apb_rd(A_RIS, "coll.ris", d);     check_eq("coll.ris_c", d, 0);
        apb_wr(A_LOAD, 0, "coll.load0b");
        clk_mode = 4; apb_rd(A_RIS, "coll.tick", d); clk_mode = 0;
        apb_rd(A_RIS, "coll.ris_to", d); check_eq("coll.ris_to_c", d, 1);
        apb_wr(A_CTRL, 3, "coll.ctrl3");
        clk_mode = 4; apb_wr(A_KICK, 0, "coll.kick"); clk_mode = 0;
        apb_rd(A_RIS, "coll.ris_kick", d); check_eq("coll.ris_kick_c", d, 0);
        check_eq("coll.res_kick", WDOGRES, 0);
        do_reset("coll");

        // PRESC=3 with WDOGCLKEN every second cycle: one decrement per 8 PCLK.
        apb_wr(A_PRESC, 3, "pre.presc");
        apb_wr(A_LOAD, 100, "pre.load");
        apb_wr(A_CTRL, 1, "pre.ctrl");
        clk_mode = 2;
        t1 = -1; t2 = -1;
        apb_rd(A_VALUE, "pre.rd", prev);
        for (int i = 0; i < 40 && t2 < 0; i++) begin
            apb_rd(A_VALUE, "pre.rd", d);
            if (d != prev) begin
                if (t1 < 0) t1 = cyc; else t2 = cyc;
            end
            prev = d;
        end
        check_eq("pre.period", t2 - t1, 8);
        clk_mode = 0;
        do_reset("pre");

        // Random traffic against the model.
        for (int op = 0; op < 400; op++) begin
            clk_mode = $urandom_range(0, 3);
            a = addr_tab[$urandom_range(0, 11)];
            if ($urandom_range(0, 1) == 1) begin
                case (a)
                    A_LOAD, A_WINDOW: d = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 12);
                    A_CTRL:           d = $urandom_range(0, 7);
                    A_PRESC:          d = $urandom_range(0, 2);
                    A_LOCK:           d = ($urandom_range(0, 3) == 0) ? $urandom : KEY;
                    default:          d = $urandom;
                endcase
                apb_wr(a, d, "rnd.wr");
            end else begin
                apb_rd(a, "rnd.rd", d);
            end
            repeat ($urandom_range(0, 2)) step();
            if ((m.res && $urandom_range(0, 3) == 0) || op % 97 == 96) do_reset("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
